// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - uniform pipeline register bank with hold/bubble/flush sequencing
// and a multicycle-op timer that freezes the younger stages while older ones drain.
module pipe_stage_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int WIDTH      = 32,
  parameter int MC_IDX     = 1,
  parameter int MC_LAT     = 4,
  parameter int IDXW       = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_STAGES-1:0]       hold_req,
  input  logic                        flush_req,
  input  logic [IDXW-1:0]             flush_upto,
  input  logic                        mc_start,
  output logic                        mc_busy,
  output logic [NUM_STAGES*WIDTH-1:0] stage_data,
  output logic [NUM_STAGES-1:0]       stage_valid,
  output logic [NUM_STAGES-1:0]       freeze_out
);

  localparam int CNTW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MC_LAT - 2);

  logic [WIDTH-1:0]      r_data [NUM_STAGES];
  logic [NUM_STAGES-1:0] r_valid;
  logic [CNTW-1:0]       r_cnt;
  logic                  r_mc_done;

  logic                  w_mc_go;
  logic                  w_mc_busy;
  logic [NUM_STAGES-1:0] w_freeze;
  logic [NUM_STAGES-1:0] w_kill;
  logic [NUM_STAGES-1:0] w_bubble;
  logic [NUM_STAGES-1:0] w_src_valid;
  logic [WIDTH-1:0]      w_src_data [NUM_STAGES];

  assign w_mc_go   = mc_start & r_valid[MC_IDX] & (r_cnt == '0) & ~r_mc_done;
  assign w_mc_busy = (r_cnt != '0) | w_mc_go;

  // A hold at stage k freezes every younger register; accumulate from the oldest end.
  always_comb begin
    logic w_acc;
    w_freeze = '0;
    w_kill   = '0;
    w_acc    = 1'b0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      w_freeze[j] = w_acc | (w_mc_busy & (j <= MC_IDX));
      w_kill[j]   = flush_req & (j <= int'(flush_upto));
      w_acc       = w_acc | hold_req[j];
    end
  end

  always_comb begin
    w_bubble       = '0;
    w_src_valid    = '0;
    w_src_data[0]  = in_data;
    w_src_valid[0] = in_valid;
    for (int k = 1; k < NUM_STAGES; k++) begin
      w_bubble[k]    = w_freeze[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_valid[k] = r_valid[k-1];
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (!reset || w_kill[k] || (!w_freeze[k] && w_bubble[k])) begin
        r_data[k]  <= '0;
        r_valid[k] <= 1'b0;
      end else if (!w_freeze[k]) begin
        r_data[k]  <= w_src_data[k];
        r_valid[k] <= w_src_valid[k];
      end
    end
  end

  // mc_done blocks a restart of the same op until register MC_IDX takes new content.
  always_ff @(posedge clock) begin
    if (!reset || w_kill[MC_IDX]) begin
      r_cnt     <= '0;
      r_mc_done <= 1'b0;
    end else if (w_mc_go) begin
      r_cnt     <= CNT_LOAD;
      r_mc_done <= (MC_LAT == 2);
    end else if (r_cnt != '0) begin
      r_cnt     <= r_cnt - CNTW'(1);
      r_mc_done <= (r_cnt == CNTW'(1));
    end else if (!w_freeze[MC_IDX]) begin
      r_mc_done <= 1'b0;
    end
  end

  always_comb begin
    stage_data = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_data[k*WIDTH +: WIDTH] = r_data[k];
    end
  end

  assign stage_valid = r_valid;
  assign freeze_out  = w_freeze;
  assign mc_busy     = w_mc_busy;
  assign in_ready    = ~w_freeze[0];

endmodule
